// File: rtl/aes_package.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_package: shared types and constants for the AES block scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
package aes_package;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_REQ   = 3'd1,
    S_LOAD_WAIT  = 3'd2,
    S_ENC_START  = 3'd3,
    S_ENC_WAIT   = 3'd4,
    S_STORE_REQ  = 3'd5,
    S_STORE_WAIT = 3'd6,
    S_DONE       = 3'd7
  } aes_sched_state_t;

  localparam int unsigned AES_BLOCK_BYTES   = 16;
  localparam int unsigned AES_SCHED_TIMEOUT = 1024;

endpackage
`default_nettype wire

// File: rtl/aes_sched_watchdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_sched_watchdog: per-state cycle counter that flags a stalled wait state.
// Rev 1.0
// ----------------------------------------------------------------------------
module aes_sched_watchdog
  import aes_package::*;
#(
  parameter int unsigned TIMEOUT = AES_SCHED_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || !count_en_i) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Counter holds the cycles already spent in the state, so TIMEOUT-1 marks the last allowed one.
  assign expired_o = count_en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/aes_block_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_block_scheduler: counted load/encrypt/store sequencer for multi-block jobs.
// Optional watchdog abort enabled by AES_SCHED_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module aes_block_scheduler
  import aes_package::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BLOCK_BYTES = AES_BLOCK_BYTES
`ifdef AES_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT     = AES_SCHED_TIMEOUT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] cfg_src_addr_i,
  input  logic [ADDR_W-1:0] cfg_dst_addr_i,
  input  logic [CNT_W-1:0]  cfg_nblocks_i,
  output logic              src_req_o,
  output logic [ADDR_W-1:0] src_addr_o,
  input  logic              src_ready_i,
  input  logic              src_done_i,
  output logic              eng_start_o,
  input  logic              eng_done_i,
  output logic              sink_req_o,
  output logic [ADDR_W-1:0] sink_addr_o,
  input  logic              sink_ready_i,
  input  logic              sink_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  blk_idx_o,
  output logic              error_o
);

  aes_sched_state_t  state_q, state_d, state_adv;
  logic [CNT_W-1:0]  blk_idx_q, blk_idx_d, nblocks_q, nblocks_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d, sink_addr_q, sink_addr_d;
  logic              error_q, error_d;
  logic              timeout;

`ifdef AES_SCHED_TIMEOUT_EN
  logic wd_count_en;
  assign wd_count_en = state_q inside {S_LOAD_REQ, S_LOAD_WAIT, S_ENC_WAIT,
                                       S_STORE_REQ, S_STORE_WAIT};

  aes_sched_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .count_en_i (wd_count_en),
    .clear_i    (state_adv != state_q),
    .expired_o  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      blk_idx_q   <= '0;
      nblocks_q   <= '0;
      src_addr_q  <= '0;
      sink_addr_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_idx_q   <= blk_idx_d;
      nblocks_q   <= nblocks_d;
      src_addr_q  <= src_addr_d;
      sink_addr_q <= sink_addr_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_adv = state_q;
    unique case (state_q)
      S_IDLE:       if (start_i) state_adv = (cfg_nblocks_i == '0) ? S_DONE : S_LOAD_REQ;
      S_LOAD_REQ:   if (src_ready_i) state_adv = S_LOAD_WAIT;
      S_LOAD_WAIT:  if (src_done_i) state_adv = S_ENC_START;
      S_ENC_START:  state_adv = S_ENC_WAIT;
      S_ENC_WAIT:   if (eng_done_i) state_adv = S_STORE_REQ;
      S_STORE_REQ:  if (sink_ready_i) state_adv = S_STORE_WAIT;
      S_STORE_WAIT: if (sink_done_i)
                      state_adv = (blk_idx_q == nblocks_q - CNT_W'(1)) ? S_DONE : S_LOAD_REQ;
      S_DONE:       state_adv = S_IDLE;
      default:      state_adv = S_IDLE;
    endcase
    state_d = timeout ? S_DONE : state_adv;
  end

  // Addresses step incrementally, which equals base + idx*BLOCK_BYTES modulo 2^ADDR_W.
  always_comb begin
    blk_idx_d   = blk_idx_q;
    nblocks_d   = nblocks_q;
    src_addr_d  = src_addr_q;
    sink_addr_d = sink_addr_q;
    error_d     = error_q;
    if (state_q == S_IDLE && start_i) begin
      blk_idx_d   = '0;
      nblocks_d   = cfg_nblocks_i;
      src_addr_d  = cfg_src_addr_i;
      sink_addr_d = cfg_dst_addr_i;
      error_d     = 1'b0;
    end else if (state_q == S_STORE_WAIT && state_d == S_LOAD_REQ) begin
      blk_idx_d   = blk_idx_q + CNT_W'(1);
      src_addr_d  = src_addr_q + ADDR_W'(BLOCK_BYTES);
      sink_addr_d = sink_addr_q + ADDR_W'(BLOCK_BYTES);
    end
    if (timeout) error_d = 1'b1;
  end

  always_comb begin
    src_req_o   = 1'b0;
    sink_req_o  = 1'b0;
    eng_start_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = 1'b1;
    unique case (state_q)
      S_IDLE:      busy_o      = 1'b0;
      S_LOAD_REQ:  src_req_o   = 1'b1;
      S_ENC_START: eng_start_o = 1'b1;
      S_STORE_REQ: sink_req_o  = 1'b1;
      S_DONE:      done_o      = 1'b1;
      default:     ;
    endcase
  end

  assign src_addr_o  = src_addr_q;
  assign sink_addr_o = sink_addr_q;
  assign blk_idx_o   = blk_idx_q;
  assign error_o     = error_q;

endmodule
`default_nettype wire
